// File: rtl/kanagawa_fifo_pop_adapter_if.sv
// Bundles the upstream Kanagawa FIFO read port and the downstream valid/ready stream.
// A word moves on out_data in any cycle where out_valid and out_ready are both high;
// once out_valid rises it stays high and out_data stays stable until that transfer.
interface kanagawa_fifo_pop_adapter_if #(
    parameter int WIDTH = 32
);
    logic             fifo_empty;
    logic             fifo_rdreq;
    logic [WIDTH-1:0] fifo_q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  fifo_empty, fifo_q, out_ready,
        output fifo_rdreq, out_valid, out_data
    );

    modport master (
        output fifo_empty, fifo_q, out_ready,
        input  fifo_rdreq, out_valid, out_data
    );
endinterface

// File: rtl/kanagawa_fifo_pop_adapter.sv
// Drains a fixed-latency Kanagawa FIFO read port into a valid/ready stream via a credit-checked buffer.
// Optional simulation checks are compiled in with KANAGAWA_FIFO_POP_ADAPTER_CHECK_EN.
module kanagawa_fifo_pop_adapter #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 0,
    parameter int BUF_DEPTH    = READ_LATENCY + 1
) (
    input  logic                           clock,
    input  logic                           rst,
    kanagawa_fifo_pop_adapter_if.slave     bus,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SW = CW + 1;

    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] buffer [2**PW];
    logic             pop;
    logic             wr_en;
    logic             credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop = bus.out_valid & bus.out_ready;
    // A word leaving this cycle funds a read issued in the same cycle.
    assign credit = ({1'b0, count} + {1'b0, inflight}) < (SW'(BUF_DEPTH) + SW'(pop));
    assign bus.fifo_rdreq = rst & ~bus.fifo_empty & credit;

    generate
        if (READ_LATENCY == 0) begin : g_show_ahead
            assign wr_en = bus.fifo_rdreq;
        end else begin : g_pipelined
            logic [READ_LATENCY-1:0] flag_sr;
            // Flags mark issued reads; clearing them on reset discards stale returns.
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) begin
                    flag_sr <= '0;
                end else begin
                    flag_sr <= (flag_sr << 1) | READ_LATENCY'(bus.fifo_rdreq);
                end
            end
            assign wr_en = flag_sr[READ_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            inflight <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({bus.fifo_rdreq, wr_en})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            buffer[wr_ptr] <= bus.fifo_q;
        end
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = buffer[rd_ptr];
    assign occupancy     = count;

`ifdef KANAGAWA_FIFO_POP_ADAPTER_CHECK_EN
    logic [WIDTH-1:0] prev_data;
    logic             prev_hold;

    always @(posedge clock) begin
        if (rst) begin
            assert (!(bus.fifo_rdreq && bus.fifo_empty))
                else $error("kanagawa_fifo_pop_adapter: rdreq while empty");
            assert (!(wr_en && !pop && count == CW'(BUF_DEPTH)))
                else $error("kanagawa_fifo_pop_adapter: write into full buffer");
            assert (inflight <= CW'(READ_LATENCY))
                else $error("kanagawa_fifo_pop_adapter: inflight above read latency");
            assert (!(prev_hold && bus.out_data !== prev_data))
                else $error("kanagawa_fifo_pop_adapter: out_data changed while stalled");
        end
        prev_hold <= rst && bus.out_valid && !bus.out_ready;
        prev_data <= bus.out_data;
    end
`endif
endmodule

// File: tb/tb_kanagawa_fifo_pop_adapter.sv
// Directed bench: three adapters (READ_LATENCY 0, 1, 2), each fed by a small FIFO model.
module tb_kanagawa_fifo_pop_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [2:0]  ready;
    logic [2:0]  stut;
    logic [2:0]  rdreq_w;
    logic [2:0]  empty_w;
    logic [2:0]  valid_w;
    logic [31:0] data_w [3];
    logic [1:0]  occ_w [3];
    int          avail [3];
    int          rd_cnt [3];
    logic [31:0] src [3][64];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int RL = g;
        localparam int QI = (g == 0) ? 0 : g - 1;
        kanagawa_fifo_pop_adapter_if #(.WIDTH(32)) bus ();
        logic [$clog2(RL + 2)-1:0] occ;
        int          rd_idx = 0;
        logic [31:0] pipe [2];

        kanagawa_fifo_pop_adapter #(.WIDTH(32), .READ_LATENCY(RL)) dut (
            .clock     (clk),
            .rst       (rst_n[g]),
            .bus       (bus),
            .occupancy (occ)
        );

        // Upstream FIFO model: show-ahead for latency 0, else a data pipe of RL stages.
        assign bus.fifo_empty = (rd_idx >= avail[g]) || stut[g];
        assign bus.fifo_q     = (RL == 0) ? src[g][rd_idx[5:0]] : pipe[QI];
        assign bus.out_ready  = ready[g];

        always @(posedge clk) begin
            if (bus.fifo_rdreq) rd_idx <= rd_idx + 1;
            pipe[0] <= bus.fifo_rdreq ? src[g][rd_idx[5:0]] : 32'hDEAD_BEEF;
            pipe[1] <= pipe[0];
        end

        assign rdreq_w[g] = bus.fifo_rdreq;
        assign empty_w[g] = bus.fifo_empty;
        assign valid_w[g] = bus.out_valid;
        assign data_w[g]  = bus.out_data;
        assign occ_w[g]   = 2'(occ);
        assign rd_cnt[g]  = rd_idx;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    initial begin
        int n;
        int got;
        rst_n = '0;
        ready = '0;
        stut  = '0;
        for (int g = 0; g < 3; g++) begin
            avail[g] = 0;
            for (int i = 0; i < 64; i++) src[g][i] = 32'hEEEE_0000 | 32'(i);
        end
        for (int i = 0; i < 16; i++) src[2][i] = 32'(i);
        src[2][16] = 32'hBAD0_0001;
        src[2][17] = 32'h0000_00C0;
        src[2][18] = 32'h0000_00C1;
        for (int i = 0; i < 6; i++) src[1][i] = 32'h100 + 32'(i);
        for (int i = 0; i < 3; i++) src[0][i] = 32'h50 + 32'(i);
        for (int i = 0; i < 8; i++) src[0][3 + i] = 32'hA0 + 32'(i);

        // Reset held with a non-empty upstream.
        avail[2] = 16;
        tick();
        tick();
        chk("rst_rdreq", rdreq_w[2], 1'b0);
        chk("rst_valid", valid_w[2], 1'b0);
        chk("rst_occ", occ_w[2], 2'd0);
        chk("rst_valid_l1", valid_w[1], 1'b0);

        // Release: read issued at once, data visible three edges later.
        rst_n[2] = 1'b1;
        ready[2] = 1'b1;
        #1;
        chk("rel_rdreq", rdreq_w[2], 1'b1);
        chk("rel_valid0", valid_w[2], 1'b0);
        tick();
        chk("lat_valid1", valid_w[2], 1'b0);
        tick();
        chk("lat_valid2", valid_w[2], 1'b0);
        tick();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid", valid_w[2], 1'b1);
            chk("stream_data", data_w[2], exp_q.pop_front());
            tick();
        end
        chk("stream_end_valid", valid_w[2], 1'b0);
        chk("stream_end_occ", occ_w[2], 2'd0);

        // Backpressure on latency 1: two reads fill the buffer, then hold.
        avail[1] = 6;
        rst_n[1] = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            n += int'(rdreq_w[1]);
            tick();
        end
        chk("bp_rdreqs", n, 2);
        chk("bp_occ", occ_w[1], 2'd2);
        chk("bp_hold", rdreq_w[1], 1'b0);
        chk("bp_head", data_w[1], 32'h100);
        ready[1] = 1'b1;
        #1;
        chk("bp_same_cycle_rdreq", rdreq_w[1], 1'b1);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(i));
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (valid_w[1]) begin
                chk("bp_data", data_w[1], exp_q.pop_front());
                got++;
            end
            tick();
        end
        chk("bp_count", got, 6);
        chk("bp_drained", valid_w[1], 1'b0);
        chk("bp_reads", rd_cnt[1], 6);

        // Full single-entry buffer: pop and refill in the same cycle.
        avail[0] = 3;
        rst_n[0] = 1'b1;
        #1;
        tick();
        chk("sim_occ_full", occ_w[0], 2'd1);
        chk("sim_hold", rdreq_w[0], 1'b0);
        chk("sim_head", data_w[0], 32'h50);
        ready[0] = 1'b1;
        #1;
        chk("sim_rdreq", rdreq_w[0], 1'b1);
        tick();
        chk("sim_occ_keep", occ_w[0], 2'd1);
        chk("sim_data1", data_w[0], 32'h51);
        tick();
        chk("sim_data2", data_w[0], 32'h52);
        chk("sim_empty_rdreq", rdreq_w[0], 1'b0);
        tick();
        chk("sim_drained", valid_w[0], 1'b0);

        // Stutter source: empty toggles every cycle.
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + 32'(i));
        avail[0] = 11;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            stut[0] = ~stut[0];
            #1;
            chk("stut_rdreq_empty", rdreq_w[0] & empty_w[0], 1'b0);
            if (valid_w[0]) begin
                chk("stut_data", data_w[0], exp_q.pop_front());
                got++;
            end
            tick();
        end
        stut[0] = 1'b0;
        chk("stut_count", got, 8);
        chk("stut_reads", rd_cnt[0], 11);

        // Reset one cycle after a read on latency 2: the stale word must vanish.
        avail[2] = 17;
        #1;
        chk("mf_rdreq", rdreq_w[2], 1'b1);
        tick();
        rst_n[2] = 1'b0;
        tick();
        rst_n[2] = 1'b1;
        #1;
        chk("mf_valid_rel", valid_w[2], 1'b0);
        chk("mf_occ_rel", occ_w[2], 2'd0);
        tick();
        chk("mf_valid_stale", valid_w[2], 1'b0);
        tick();
        chk("mf_valid_idle", valid_w[2], 1'b0);
        exp_q.push_back(32'hC0);
        exp_q.push_back(32'hC1);
        avail[2] = 19;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (valid_w[2]) begin
                chk("mf_data", data_w[2], exp_q.pop_front());
                got++;
            end
            tick();
        end
        chk("mf_count", got, 2);
        chk("mf_drained", valid_w[2], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kanagawa_fifo_pop_adapter.md
# kanagawa_fifo_pop_adapter

Downstream stage that drains a Kanagawa FIFO read interface (empty/rdreq/q) and presents its data as a valid/ready stream. It tracks in-flight reads for a FIFO with fixed read latency and holds returning words in a small register buffer, so no word is ever dropped when the consumer stalls. It sits between any Kanagawa FIFO, including register-based single-entry FIFOs, and a valid/ready consumer.

## Interface
- WIDTH, 32, data width in bits
- READ_LATENCY, 0, cycles from a rdreq to valid q. 0 means show-ahead: q is valid whenever empty is low. Legal values are 0..2.
- BUF_DEPTH, READ_LATENCY+1, entries in the output buffer. Derived; must not be overridden.
- clock  in  1  sole clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-low reset
- fifo_empty  in  1  empty flag from the upstream FIFO
- fifo_rdreq  out  1  read request to the upstream FIFO
- fifo_q  in  WIDTH  read data from the upstream FIFO
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word this cycle
- out_data  out  WIDTH  head of the output buffer
- occupancy  out  $clog2(BUF_DEPTH+1)  number of buffered words, for debug and perf

## Operation
- State: a circular buffer of BUF_DEPTH registers with rd_ptr and wr_ptr wrapping modulo BUF_DEPTH, a count register, an inflight counter (0..READ_LATENCY), and a READ_LATENCY-deep shift register of issued-read flags.
- pop = out_valid & out_ready.
- Credit rule: fifo_rdreq = !fifo_empty & (count + inflight - pop < BUF_DEPTH). The rule is evaluated combinationally, so a same-cycle pop frees a slot.
- fifo_rdreq is never asserted while fifo_empty is high.
- READ_LATENCY=0: fifo_q is written to buffer[wr_ptr] in the same cycle as fifo_rdreq.
- READ_LATENCY>0: the flag shifted in with fifo_rdreq emerges READ_LATENCY cycles later and writes fifo_q that cycle.
- inflight increments on rdreq and decrements on arrival. A simultaneous rdreq and arrival leaves it unchanged.
- out_valid = (count != 0). out_data = buffer[rd_ptr]. A pop advances rd_ptr.
- A simultaneous write and pop leaves count unchanged and advances both pointers.
- Overflow cannot happen by construction: the credit rule guarantees a slot for every in-flight word.
- Reset: count, inflight, pointers and the flag shift register are cleared. Buffer data is not reset.
- Reset mid-operation: in-flight words returning after reset deasserts are ignored, because their flags were cleared. The upstream FIFO must be reset together with this block.

## Timing
- Reset values: fifo_rdreq=0 (forced while rst is low), out_valid=0, occupancy=0, out_data=undefined (X).
- Latency from rdreq to out_valid is READ_LATENCY+1 cycles.
- Sustained throughput is 1 word/cycle when fifo_empty=0 and out_ready=1, for every legal READ_LATENCY.
- out_valid and out_data are registered.
- fifo_rdreq is combinational from fifo_empty, out_ready and state. out_ready must not depend combinationally on fifo_rdreq.
- Valid/ready rules: once out_valid rises, out_data stays stable until popped. out_valid never drops without a pop.
- A stutter-mode upstream FIFO (at most one write per two cycles) is drained at its own rate; no bubbles are added beyond those from fifo_empty.

## Configuration
- KANAGAWA_FIFO_POP_ADAPTER_CHECK_EN defined: simulation assertions are compiled in. Each fires $error on the clock edge.
  - fifo_rdreq while fifo_empty is high.
  - Write into a full buffer.
  - inflight above READ_LATENCY.
  - out_data changing while out_valid & !out_ready.
- Undefined: no assertion logic. Functional behaviour is identical.

## Test plan
- Reset: hold rst=0 with fifo_empty=0 → fifo_rdreq=0, out_valid=0, occupancy=0. Release rst → first rdreq in the next cycle.
- Streaming: READ_LATENCY=2, push words 0x00..0x0F, out_ready=1 → out_data 0x00..0x0F in order at 1 word/cycle. First out_valid appears 3 cycles after the first rdreq.
- Backpressure: READ_LATENCY=1, out_ready=0 for 10 cycles → exactly 2 rdreqs issued, then occupancy=2 and rdreq held low. Raise out_ready → data order preserved, no loss or duplication.
- Simultaneous events: occupancy=BUF_DEPTH with out_ready=1 and fifo_empty=0 → rdreq asserts in the same cycle as the pop, and occupancy stays at BUF_DEPTH.
- Reset mid-flight: READ_LATENCY=2, assert rst one cycle after an rdreq → after release, out_valid stays 0 until new data arrives, and the stale word is never presented.
- Stutter source: upstream empty toggles every cycle, values 0xA0..0xA7 → all eight words delivered in order, with fifo_rdreq only on non-empty cycles.
